// File: rtl/lspc_lb_writer_if.sv
// Sprite-strip handshake bundle between the sprite fetcher and the line-buffer writer.
// Latency: none, wires only.
// Backpressure: source holds SPR_* stable while SPR_VALID=1 until a CE edge sees SPR_READY=1.
interface lspc_lb_writer_if;
  logic        SPR_VALID;
  logic        SPR_READY;
  logic [8:0]  SPR_X;
  logic [7:0]  SPR_PAL;
  logic        SPR_FLIPX;
  logic [63:0] SPR_PIX;

  // Sprite fetcher side
  modport master (
    output SPR_VALID,
    output SPR_X,
    output SPR_PAL,
    output SPR_FLIPX,
    output SPR_PIX,
    input  SPR_READY
  );

  // Line-buffer writer side
  modport slave (
    input  SPR_VALID,
    input  SPR_X,
    input  SPR_PAL,
    input  SPR_FLIPX,
    input  SPR_PIX,
    output SPR_READY
  );
endinterface

// File: rtl/lspc_lb_writer.sv
// Line-buffer writer: takes 16-pixel sprite strips and writes them into the write pair of line buffers.
// Latency: 1 CE cycle LOAD, then 8 (even X) or 9 (odd X) CE cycles WRITE; all outputs registered.
// Backpressure: SPR_READY only in IDLE with no LINE_START; LINE_START aborts any strip in flight.
module lspc_lb_writer (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   CE_6MB,
  input  logic                   LINE_START,
  lspc_lb_writer_if.slave        spr,
  output logic [23:0]            PBUS,
  output logic                   PCK2,
  output logic                   LD1,
  output logic                   LD2,
  output logic [3:0]             WE,
  output logic [3:0]             CK,
  output logic [3:0]             GAD,
  output logic [3:0]             GBD,
  output logic                   TMS0,
  output logic                   SS1,
  output logic                   SS2,
  output logic                   BUSY
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  k;        // pair counter, index of the cycle currently on the outputs
  logic        x0_r;     // odd start X shifts the strip by one position against the even/odd pair
  logic [63:0] pix_r;    // strip pixels already in logical (flip-corrected) order

  logic [63:0] pix_in;
  logic [3:0]  k_nxt;
  logic [5:0]  pos_a;
  logic [5:0]  pos_b;
  logic [3:0]  pix_a;
  logic [3:0]  pix_b;
  logic        last_k;
  logic [3:0]  we_nxt;
  logic [3:0]  ck_pair;
  logic [7:0]  addr_r;
  logic [7:0]  addr_l;

  assign spr.SPR_READY = (state == S_IDLE) & ~LINE_START;

  // The displayed pair is cleared after it has been read out.
  assign SS1 = TMS0;
  assign SS2 = ~TMS0;

  // Reorder incoming nibbles so logical pixel 0 always sits in bits [3:0].
  always_comb begin
    pix_in = '0;
    for (int i = 0; i < 16; i++) begin
      pix_in[4*i +: 4] = spr.SPR_FLIPX ? spr.SPR_PIX[4*(15-i) +: 4] : spr.SPR_PIX[4*i +: 4];
    end
  end

  // Strip-relative pixel positions for the cycle about to be presented; out-of-strip reads as 0.
  always_comb begin
    k_nxt   = (state == S_LOAD) ? 4'd0 : k + 4'd1;
    // Even position = 2*K - X[0]; a negative result wraps to 63 and drops out of range.
    pos_a   = {1'b0, k_nxt, 1'b0} - {5'd0, x0_r};
    pos_b   = pos_a + 6'd1;
    pix_a   = (pos_a < 6'd16) ? pix_r[{pos_a[3:0], 2'b00} +: 4] : 4'd0;
    pix_b   = (pos_b < 6'd16) ? pix_r[{pos_b[3:0], 2'b00} +: 4] : 4'd0;
    last_k  = (k == (x0_r ? 4'd8 : 4'd7));
    // Colour index 0 is transparent and never written.
    we_nxt  = TMS0 ? {2'b00, (pix_b != 4'd0), (pix_a != 4'd0)}
                   : {(pix_b != 4'd0), (pix_a != 4'd0), 2'b00};
    ck_pair = TMS0 ? 4'b0011 : 4'b1100;
    addr_r  = spr.SPR_X[8:1];
    addr_l  = spr.SPR_X[8:1] + {7'd0, spr.SPR_X[0]};
  end

  // Strip FSM with all line-buffer controls registered alongside the state.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= S_IDLE;
      k     <= 4'd0;
      x0_r  <= 1'b0;
      pix_r <= '0;
      PBUS  <= 24'd0;
      PCK2  <= 1'b0;
      LD1   <= 1'b0;
      LD2   <= 1'b0;
      WE    <= 4'd0;
      CK    <= 4'd0;
      GAD   <= 4'd0;
      GBD   <= 4'd0;
      TMS0  <= 1'b0;
      BUSY  <= 1'b0;
    end else if (CE_6MB) begin
      if (LINE_START) begin
        // New line: swap display/write pairs and drop any strip in flight.
        TMS0  <= ~TMS0;
        state <= S_IDLE;
        PCK2  <= 1'b0;
        LD1   <= 1'b0;
        LD2   <= 1'b0;
        WE    <= 4'd0;
        CK    <= 4'd0;
        GAD   <= 4'd0;
        GBD   <= 4'd0;
        BUSY  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (spr.SPR_VALID) begin
              x0_r  <= spr.SPR_X[0];
              pix_r <= pix_in;
              PBUS  <= {spr.SPR_PAL, addr_r, addr_l};
              PCK2  <= 1'b1;
              LD1   <= TMS0;
              LD2   <= ~TMS0;
              BUSY  <= 1'b1;
              state <= S_LOAD;
            end
          end
          S_LOAD: begin
            PCK2  <= 1'b0;
            LD1   <= 1'b0;
            LD2   <= 1'b0;
            k     <= 4'd0;
            GAD   <= pix_a;
            GBD   <= pix_b;
            WE    <= we_nxt;
            CK    <= ck_pair;
            state <= S_WRITE;
          end
          S_WRITE: begin
            if (last_k) begin
              WE    <= 4'd0;
              CK    <= 4'd0;
              GAD   <= 4'd0;
              GBD   <= 4'd0;
              BUSY  <= 1'b0;
              state <= S_IDLE;
            end else begin
              k     <= k_nxt;
              GAD   <= pix_a;
              GBD   <= pix_b;
              WE    <= we_nxt;
              CK    <= ck_pair;
            end
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lspc_lb_writer.sv
// Bench for the line-buffer writer: directed strips plus randomized traffic against a strip-level model.
// Latency: model predicts outputs one CE edge after each input set.
// Backpressure: model accepts a strip only when idle and no LINE_START.
module tb_lspc_lb_writer;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        CE_6MB = 1'b0;
  logic        LINE_START = 1'b0;
  logic [23:0] PBUS;
  logic        PCK2, LD1, LD2, TMS0, SS1, SS2, BUSY;
  logic [3:0]  WE, CK, GAD, GBD;

  lspc_lb_writer_if spr_if ();

  lspc_lb_writer dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .CE_6MB     (CE_6MB),
    .LINE_START (LINE_START),
    .spr        (spr_if),
    .PBUS       (PBUS),
    .PCK2       (PCK2),
    .LD1        (LD1),
    .LD2        (LD2),
    .WE         (WE),
    .CK         (CK),
    .GAD        (GAD),
    .GBD        (GBD),
    .TMS0       (TMS0),
    .SS1        (SS1),
    .SS2        (SS2),
    .BUSY       (BUSY)
  );

  always #5 CLK = ~CLK;

  // One expected output set per active CE cycle of a strip.
  typedef struct packed {
    logic [3:0] we;
    logic [3:0] ck;
    logic       ld1;
    logic       ld2;
    logic       pck2;
    logic [3:0] gad;
    logic [3:0] gbd;
    logic       busy;
  } rec_t;

  rec_t        q[$];
  logic        tms_m = 1'b0;
  logic [23:0] pbus_m = 24'd0;
  int          n_tot = 0;
  int          n_pass = 0;

  localparam logic [63:0] PIXA = 64'hFEDCBA9876543210;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic check_outputs();
    rec_t e;
    e = '0;
    if (q.size() > 0) e = q[0];
    chk("we",   WE,   e.we);
    chk("ck",   CK,   e.ck);
    chk("ld1",  LD1,  e.ld1);
    chk("ld2",  LD2,  e.ld2);
    chk("pck2", PCK2, e.pck2);
    chk("gad",  GAD,  e.gad);
    chk("gbd",  GBD,  e.gbd);
    chk("busy", BUSY, e.busy);
    chk("pbus", PBUS, pbus_m);
    chk("tms0", TMS0, tms_m);
    chk("ss1",  SS1,  tms_m);
    chk("ss2",  SS2,  !tms_m);
  endtask

  // Build the expected LOAD and WRITE cycles from absolute line positions.
  task automatic push_strip(input logic [8:0] x, input logic [7:0] pal, input bit flip,
                            input logic [63:0] pix);
    logic [3:0] lg [16];
    rec_t r;
    int xi, hx, nw, a, re, ro, lb, rb;
    for (int i = 0; i < 16; i++) lg[i] = flip ? pix[4*(15-i) +: 4] : pix[4*i +: 4];
    xi = int'(x);
    hx = xi / 2;
    pbus_m = {pal, 8'(hx), 8'((hx + xi % 2) % 256)};
    r = '0;
    r.ld1 = tms_m;
    r.ld2 = !tms_m;
    r.pck2 = 1'b1;
    r.busy = 1'b1;
    q.push_back(r);
    nw = (xi % 2 == 1) ? 9 : 8;
    lb = tms_m ? 0 : 2;
    rb = tms_m ? 1 : 3;
    for (int kk = 0; kk < nw; kk++) begin
      a  = (2 * (hx + kk)) % 512;
      re = (a - xi + 512) % 512;
      ro = (a + 1 - xi + 512) % 512;
      r = '0;
      r.busy = 1'b1;
      r.gad = (re < 16) ? lg[re] : 4'd0;
      r.gbd = (ro < 16) ? lg[ro] : 4'd0;
      r.ck[lb] = 1'b1;
      r.ck[rb] = 1'b1;
      r.we[lb] = (r.gad != 4'd0);
      r.we[rb] = (r.gbd != 4'd0);
      q.push_back(r);
    end
  endtask

  // One clock: drive inputs, check ready, advance model on the edge, check outputs.
  task automatic step(input bit ce, input bit ls, input bit vld, input logic [8:0] x,
                      input logic [7:0] pal, input bit flip, input logic [63:0] pix);
    CE_6MB = ce;
    LINE_START = ls;
    spr_if.SPR_VALID = vld;
    spr_if.SPR_X = x;
    spr_if.SPR_PAL = pal;
    spr_if.SPR_FLIPX = flip;
    spr_if.SPR_PIX = pix;
    #1;
    chk("ready", spr_if.SPR_READY, (q.size() == 0) && !ls);
    @(posedge CLK);
    if (ce) begin
      if (ls) begin
        tms_m = !tms_m;
        q.delete();
      end else if (q.size() > 0) begin
        void'(q.pop_front());
      end else if (vld) begin
        push_strip(x, pal, flip, pix);
      end
    end
    @(negedge CLK);
    check_outputs();
  endtask

  task automatic idle_step();
    step(1'b1, 1'b0, 1'b0, 9'd0, 8'd0, 1'b0, 64'd0);
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    #1;
    q.delete();
    tms_m = 1'b0;
    pbus_m = 24'd0;
    check_outputs();
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    logic [63:0] rp;
    logic [8:0]  rx;
    spr_if.SPR_VALID = 1'b0;
    spr_if.SPR_X = '0;
    spr_if.SPR_PAL = '0;
    spr_if.SPR_FLIPX = 1'b0;
    spr_if.SPR_PIX = '0;
    #2;
    check_outputs();
    chk("rst_ss2", SS2, 1'b1);
    @(negedge CLK);
    nRST = 1'b1;

    // Even X, top pair
    step(1'b1, 1'b0, 1'b1, 9'h020, 8'h5A, 1'b0, PIXA);
    chk("r030_pbus", PBUS, 24'h5A1010);
    chk("r030_ld2", LD2, 1'b1);
    idle_step();
    chk("r030_k0_gad", GAD, 4'h0);
    chk("r030_k0_gbd", GBD, 4'h1);
    chk("r030_k0_we", WE, 4'b1000);
    idle_step();
    chk("r030_k1_we", WE, 4'b1100);
    for (int i = 0; i < 6; i++) idle_step();
    idle_step();
    chk("r030_done_busy", BUSY, 1'b0);

    // Odd X: nine write cycles
    step(1'b1, 1'b0, 1'b1, 9'h021, 8'h5A, 1'b0, PIXA);
    chk("r031_pbus_l", PBUS[7:0], 8'h11);
    chk("r031_pbus_r", PBUS[15:8], 8'h10);
    idle_step();
    chk("r031_k0_we2", WE[2], 1'b0);
    chk("r031_k0_gbd", GBD, 4'h0);
    for (int i = 0; i < 8; i++) idle_step();
    chk("r031_k8_gad", GAD, 4'hF);
    chk("r031_k8_gbd", GBD, 4'h0);
    chk("r031_k8_busy", BUSY, 1'b1);
    idle_step();
    chk("r031_done_busy", BUSY, 1'b0);

    // Flipped strip with a single opaque pixel
    step(1'b1, 1'b0, 1'b1, 9'h000, 8'h33, 1'b1, 64'h1);
    for (int kk = 0; kk < 8; kk++) begin
      idle_step();
      if (kk == 7) begin
        chk("r032_k7_gbd", GBD, 4'h1);
        chk("r032_k7_we", WE, 4'b1000);
      end
    end
    idle_step();

    // Swap pairs, then wrap at the right edge
    step(1'b1, 1'b1, 1'b0, 9'd0, 8'd0, 1'b0, 64'd0);
    chk("ls_tms0", TMS0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 9'h1FE, 8'hA5, 1'b0, PIXA);
    chk("r033_pbus", PBUS[15:0], 16'hFFFF);
    chk("r033_ld1", LD1, 1'b1);
    idle_step();
    chk("r033_k0_we", WE, 4'b0010);
    for (int i = 0; i < 8; i++) idle_step();

    // Abort at K=3
    step(1'b1, 1'b0, 1'b1, 9'h040, 8'h11, 1'b0, PIXA);
    for (int i = 0; i < 4; i++) idle_step();
    step(1'b1, 1'b1, 1'b1, 9'h040, 8'h11, 1'b0, PIXA);
    chk("r034_tms0", TMS0, 1'b0);
    chk("r034_we", WE, 4'd0);
    chk("r034_busy", BUSY, 1'b0);
    chk("r034_rdy_ls", spr_if.SPR_READY, 1'b0);
    LINE_START = 1'b0;
    #1;
    chk("r034_rdy_after", spr_if.SPR_READY, 1'b1);
    @(negedge CLK);

    // Async reset mid-strip on the bottom pair
    step(1'b1, 1'b1, 1'b0, 9'd0, 8'd0, 1'b0, 64'd0);
    step(1'b1, 1'b0, 1'b1, 9'h010, 8'h22, 1'b0, PIXA);
    for (int i = 0; i < 3; i++) idle_step();
    chk("r035_pre_tms0", TMS0, 1'b1);
    do_reset();
    chk("r035_tms0", TMS0, 1'b0);
    for (int i = 0; i < 10; i++) idle_step();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 699) == 0) do_reset();
      rp = '0;
      for (int j = 0; j < 16; j++)
        rp[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      case ($urandom_range(0, 5))
        0: rx = 9'h000;
        1: rx = 9'h1FF;
        2: rx = 9'h1FE;
        default: rx = 9'($urandom_range(0, 511));
      endcase
      step($urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)),
           rx, 8'($urandom), 1'($urandom_range(0, 1)), rp);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/lspc_lb_writer.md
LSPC_LB_WRITER -- requirements
Module: lspc_lb_writer

Interface
REQ-001 CLK  in  1  system clock; all state updates on rising edge.
REQ-002 nRST  in  1  asynchronous active-low reset.
REQ-003 CE_6MB  in  1  pixel-rate enable; state advances only on CLK edges with CE_6MB=1.
REQ-004 LINE_START  in  1  one-CE pulse at start of each line's h-blank.
REQ-005 SPR_VALID / SPR_READY  in / out  1 / 1  sprite-strip handshake; a transfer occurs on a CE edge with both high.
REQ-006 SPR_X  in  9  strip start X (pixels); SPR_PAL in 8 palette; SPR_FLIPX in 1; SPR_PIX in 64 (16 x 4-bit pixels, pixel 0 = bits [3:0]).
REQ-007 PBUS  out  24  [7:0] left (even) LB address, [15:8] right (odd) LB address, [23:16] palette.
REQ-008 PCK2  out  1  palette latch strobe; LD1, LD2 out 1 each, address load for bottom/top pair.
REQ-009 WE  out  4  LB write enables [BL,BR,TL,TR]; CK out 4, LB address-advance strobes, same order.
REQ-010 GAD, GBD  out  4 each  even-/odd-position pixel for current write cycle.
REQ-011 TMS0  out  1  display/write pair select; SS1, SS2 out 1 each, clear enables for bottom/top pair.
REQ-012 BUSY  out  1  high in LOAD or WRITE.

Function
REQ-013 FSM states IDLE, LOAD, WRITE; SPR_READY = (state==IDLE) & ~LINE_START.
REQ-014 Transfer in IDLE: capture SPR_* into registers, go to LOAD.
REQ-015 LOAD (one CE cycle): PBUS[7:0]=X[8:1]+X[0] (mod 256), PBUS[15:8]=X[8:1], PBUS[23:16]=PAL; PCK2=1; write-pair LD=1; next WRITE, pair counter K=0.
REQ-016 Write pair: TMS0=0 -> top (LD2, WE/CK[3:2]); TMS0=1 -> bottom (LD1, WE/CK[1:0]).
REQ-017 Pixel order: logical pixel i = SPR_PIX nibble i, or nibble 15-i if SPR_FLIPX=1.
REQ-018 Cycle K: GAD = pixel at X position 2*(X[8:1]+K) relative to strip, GBD = next position; positions outside 0..15 give 0.
REQ-019 WRITE lasts 8 CE cycles if X[0]=0, 9 if X[0]=1; K increments each cycle; after last, return to IDLE.
REQ-020 In WRITE, write-pair CK bits both 1 every cycle; left WE = (GAD!=0), right WE = (GBD!=0); index 0 transparent, never written.
REQ-021 Display-pair WE, CK and LD always 0.
REQ-022 X wraps mod 512 (addresses mod 256); no clipping.
REQ-023 LINE_START on a CE edge: TMS0 toggles; any strip in LOAD/WRITE is aborted, state->IDLE, all WE/CK/LD/PCK2 0 next cycle; LINE_START wins over simultaneous SPR_VALID (no transfer).
REQ-024 SS1 = TMS0, SS2 = ~TMS0 (displayed pair cleared after read).
REQ-025 Outputs registered; GAD/GBD/WE/CK valid in same cycle as state WRITE.
REQ-026 Outside LOAD, PBUS holds last loaded value; outside WRITE, GAD=GBD=0.
REQ-027 With CE_6MB=0 all registers hold.

Reset
REQ-028 nRST low asynchronously: state IDLE, TMS0=0, PBUS=0, WE=CK=0, LD1=LD2=PCK2=0, GAD=GBD=0, BUSY=0; SS1=0, SS2=1.
REQ-029 Reset mid-strip discards strip; after release SPR_READY=1 on first cycle with LINE_START=0.

Verification
REQ-030 X=0x020, PAL=0x5A, FLIPX=0, PIX=0x FEDCBA9876543210, TMS0=0 -> LOAD PBUS=0x5A1010, LD2=1; 8 WRITE cycles, K=0 GAD=0 GBD=1, WE=4'b1000 then 4'b1100 for K>=1.
REQ-031 Same strip X=0x021 -> PBUS[7:0]=0x11, [15:8]=0x10; 9 WRITE cycles; K=0 GAD=0 (WE[2]=0), GBD=0; K=8 GAD=0xF, GBD=0.
REQ-032 FLIPX=1, X=0, PIX=0x0000_0000_0000_0001 -> only K=7 GBD=1, WE=4'b1000; all other WE=0.
REQ-033 X=0x1FE, TMS0=1 -> PBUS[15:8]=0xFF, [7:0]=0xFF; LD1=1; writes on WE[1:0]; address wrap left to LB.
REQ-034 LINE_START at WRITE K=3 -> TMS0 toggles, WE/CK=0 next cycle, BUSY=0, SPR_READY=0 that cycle, 1 after.
REQ-035 nRST low during WRITE, TMS0=1 -> immediately TMS0=0, SS2=1, WE=0; no further writes after release without new transfer.
